regfile_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the 32-entry register file. It shares the register file's single write port between two requesters: requester A (ALU/jump write-back) and requester B (load/multicycle write-back). Each requester uses a valid/ready handshake. The granted request is registered into a one-entry write stage that drives the register file write port. The block also reports read-port hazards and bypass data so the decode stage never consumes a stale operand.

---
 rtl/regfile_wb_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port: round-robin between two
// valid/ready requesters, a one-entry registered write stage, and read bypass/hazard reporting.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] rw_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic                  fwd1_en,
  output logic                  fwd2_en,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic [15:0]           contention_cnt
);

  logic                  prio_q, prio_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic                  contended;
  logic                  grant_a, grant_b, xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wait_a, wait_b;

  always_comb begin
    contended = a_valid && b_valid;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (!reset) begin
      if (contended) begin
        grant_a = !prio_q;
        grant_b = prio_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
    xfer     = grant_a || grant_b;
    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
    // Pointer moves to the loser so it wins the next contended cycle.
    prio_d   = contended ? grant_a : prio_q;
    cnt_d    = (contended && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    wait_a   = a_valid && !grant_a;
    wait_b   = b_valid && !grant_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      // Writes to x0 are accepted but never reach the array.
      wr_en_q <= xfer && (sel_addr != '0);
      if (xfer) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  always_comb begin
    a_ready        = grant_a;
    b_ready        = grant_b;
    wr_en          = wr_en_q;
    rw_addr        = wr_addr_q;
    wr_data        = wr_data_q;
    contention_cnt = cnt_q;
    fwd1_en        = wr_en_q && (wr_addr_q == rd_addr1) && (rd_addr1 != '0);
    fwd2_en        = wr_en_q && (wr_addr_q == rd_addr2) && (rd_addr2 != '0);
    fwd_data1      = fwd1_en ? wr_data_q : '0;
    fwd_data2      = fwd2_en ? wr_data_q : '0;
    hazard1        = (rd_addr1 != '0) &&
                     ((wait_a && a_addr == rd_addr1) || (wait_b && b_addr == rd_addr1));
    hazard2        = (rd_addr2 != '0) &&
                     ((wait_a && a_addr == rd_addr2) || (wait_b && b_addr == rd_addr2));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table for arbitration/hazards, a queue of expected
// write-stage states checked one cycle later, and hand sequences for reset corner cases.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, rw_addr, rd_addr1, rd_addr2;
  logic [31:0] a_data, b_data, wr_data, fwd_data1, fwd_data2;
  logic        wr_en, fwd1_en, fwd2_en, hazard1, hazard2;
  logic [15:0] contention_cnt;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .rw_addr(rw_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .hazard1(hazard1), .hazard2(hazard2), .contention_cnt(contention_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic [4:0]  rd1, rd2;
    logic        ea, eb, eh1, eh2;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } ws_t;

  vec_t vecs[$];
  ws_t  sb[$];
  ws_t  ws;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic [4:0] rd1, logic [4:0] rd2,
                              logic ea, logic eb, logic eh1, logic eh2);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.rd1 = rd1; v.rd2 = rd2; v.ea = ea; v.eb = eb; v.eh1 = eh1; v.eh2 = eh2;
    return v;
  endfunction

  // Compare the DUT write stage against the oldest scoreboard entry.
  task automatic pop_ws(input string tag);
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      ws = sb.pop_front();
      check({tag, " wr_en"}, {31'd0, wr_en}, {31'd0, ws.en});
      check({tag, " rw_addr"}, {27'd0, rw_addr}, {27'd0, ws.addr});
      check({tag, " wr_data"}, wr_data, ws.data);
    end
  endtask

  task automatic check_fwd(input string tag, input logic [4:0] rd1, input logic [4:0] rd2);
    logic e1, e2;
    e1 = ws.en && ws.addr == rd1 && rd1 != 5'd0;
    e2 = ws.en && ws.addr == rd2 && rd2 != 5'd0;
    check({tag, " fwd1_en"}, {31'd0, fwd1_en}, {31'd0, e1});
    check({tag, " fwd2_en"}, {31'd0, fwd2_en}, {31'd0, e2});
    check({tag, " fwd_data1"}, fwd_data1, e1 ? ws.data : 32'd0);
    check({tag, " fwd_data2"}, fwd_data2, e2 ? ws.data : 32'd0);
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    rd_addr1 = 0; rd_addr2 = 0;
  endtask

  initial begin
    ws_t nx;
    string tag;
    idle_inputs();
    reset = 1'b1;

    //        av aa  ad            bv ba  bd            rd1 rd2 ea eb h1 h2
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0,  32'h0,        0,  0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        5,  5,  0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 32'h33,       1, 7,  32'h77,       3,  7,  1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 7,  32'h77,       3,  7,  0, 1, 0, 0));
    vecs.push_back(mk(1, 9, 32'h99,       1, 10, 32'h1010,     9,  7,  0, 1, 1, 0));
    vecs.push_back(mk(1, 9, 32'h99,       0, 0,  32'h0,        9,  10, 1, 0, 0, 0));
    vecs.push_back(mk(1, 11, 32'hA11,     1, 21, 32'hB21,      21, 11, 1, 0, 1, 0));
    vecs.push_back(mk(1, 12, 32'hA12,     1, 21, 32'hB21,      12, 21, 0, 1, 1, 0));
    vecs.push_back(mk(1, 12, 32'hA12,     1, 22, 32'hB22,      22, 21, 1, 0, 1, 0));
    vecs.push_back(mk(1, 13, 32'hA13,     1, 22, 32'hB22,      0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(1, 13, 32'hA13,     1, 23, 32'hB23,      13, 23, 1, 0, 0, 1));
    vecs.push_back(mk(1, 14, 32'hA14,     1, 23, 32'hB23,      0,  14, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 32'h5555,     1, 0,  32'h1234,     0,  0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0,  32'h1234,     0,  0,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,  0, 0, 0, 0));

    // Reset state, with both requesters valid to show ready stays low.
    #2;
    a_valid = 1; b_valid = 1; a_addr = 4; b_addr = 6;
    #1;
    check("reset a_ready", {31'd0, a_ready}, 32'd0);
    check("reset b_ready", {31'd0, b_ready}, 32'd0);
    check("reset contention_cnt", {16'd0, contention_cnt}, 32'd0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ws.en = 0; ws.addr = 0; ws.data = 0;
    sb.push_back(ws);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      tag = $sformatf("vec%0d", i);
      pop_ws(tag);
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      rd_addr1 = vecs[i].rd1; rd_addr2 = vecs[i].rd2;
      #2;
      check({tag, " a_ready"}, {31'd0, a_ready}, {31'd0, vecs[i].ea});
      check({tag, " b_ready"}, {31'd0, b_ready}, {31'd0, vecs[i].eb});
      check({tag, " hazard1"}, {31'd0, hazard1}, {31'd0, vecs[i].eh1});
      check({tag, " hazard2"}, {31'd0, hazard2}, {31'd0, vecs[i].eh2});
      check_fwd(tag, vecs[i].rd1, vecs[i].rd2);
      nx = ws;
      nx.en = 1'b0;
      if (vecs[i].ea) begin
        nx.en = vecs[i].aa != 5'd0; nx.addr = vecs[i].aa; nx.data = vecs[i].ad;
      end else if (vecs[i].eb) begin
        nx.en = vecs[i].ba != 5'd0; nx.addr = vecs[i].ba; nx.data = vecs[i].bd;
      end
      sb.push_back(nx);
    end
    @(posedge clk);
    #1;
    pop_ws("table end");
    idle_inputs();
    check("contention_cnt after table", {16'd0, contention_cnt}, 32'd9);

    // Pointer now favours B; reset must return it to A.
    a_valid = 1; a_addr = 12; a_data = 32'hCAFEF00D;
    #1 check("pre-reset a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1;
    a_valid = 0;
    check("pre-reset wr_en", {31'd0, wr_en}, 32'd1);
    check("pre-reset wr_data", wr_data, 32'hCAFEF00D);
    reset = 1'b1;
    a_valid = 1; a_addr = 3; a_data = 32'h3; b_valid = 1; b_addr = 7; b_data = 32'h7;
    #1;
    check("mid reset wr_en", {31'd0, wr_en}, 32'd0);
    check("mid reset rw_addr", {27'd0, rw_addr}, 32'd0);
    check("mid reset wr_data", wr_data, 32'd0);
    check("mid reset a_ready", {31'd0, a_ready}, 32'd0);
    check("mid reset b_ready", {31'd0, b_ready}, 32'd0);
    check("mid reset contention_cnt", {16'd0, contention_cnt}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("post-reset a_ready", {31'd0, a_ready}, 32'd1);
    check("post-reset b_ready", {31'd0, b_ready}, 32'd0);
    check("post-reset wr_en idle", {31'd0, wr_en}, 32'd0);
    @(posedge clk);
    #1;
    check("post-reset wr_en", {31'd0, wr_en}, 32'd1);
    check("post-reset rw_addr", {27'd0, rw_addr}, 32'd3);
    check("post-reset contention_cnt", {16'd0, contention_cnt}, 32'd1);
    #1 check("post-reset b wins next", {31'd0, b_ready}, 32'd1);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
